// File: rtl/sat_sched_pkg.sv
// sat_sched_pkg: shared types and field widths for the satellite scenario
// scheduler. The field widths are also used by the register bank that writes
// the slot table.
//   state_t  - scheduler FSM state
//   slot_t   - one table slot (valid, PRN, Doppler, SNR, C/A phase, dwell)
package sat_sched_pkg;

  localparam int N_SAT_W     = 5;
  localparam int DOPPLER_W   = 8;
  localparam int SNR_W       = 8;
  localparam int CA_PHASE_W  = 16;
  // The dwell field is stored at its widest supported size; the scheduler
  // only ever compares the low DWELL_W bits, the rest stay zero.
  localparam int DWELL_MAX_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ALIGN,
    S_DWELL,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [N_SAT_W-1:0]     n_sat;
    logic [DOPPLER_W-1:0]   doppler;
    logic [SNR_W-1:0]       snr;
    logic [CA_PHASE_W-1:0]  ca_phase;
    logic [DWELL_MAX_W-1:0] dwell;
  } slot_t;

endpackage

// File: rtl/sat_sched_pick.sv
// sat_sched_pick: combinational round-robin finder for the next eligible slot.
//   elig      - per-slot eligibility vector
//   cur       - index of the slot currently active
//   from_idle - 1: search starts at slot 0; 0: search starts at cur+1
//   nxt       - first eligible slot in search order
//   found     - at least one eligible slot exists
//   wrapped   - nxt was reached only after passing slot 0 again
module sat_sched_pick #(
  parameter int N_SLOTS = 4
) (
  input  logic [N_SLOTS-1:0]         elig,
  input  logic [$clog2(N_SLOTS)-1:0] cur,
  input  logic                       from_idle,
  output logic [$clog2(N_SLOTS)-1:0] nxt,
  output logic                       found,
  output logic                       wrapped
);

  localparam int IDX_W = $clog2(N_SLOTS);

  // Positions are kept one bit wider than an index so that a position at or
  // beyond N_SLOTS marks a wrap; N_SLOTS is a power of two, so the low bits
  // are the slot index.
  logic [IDX_W:0] start;
  logic [IDX_W:0] pos;

  always_comb begin
    nxt     = '0;
    found   = 1'b0;
    wrapped = 1'b0;
    pos     = '0;
    start   = from_idle ? '0 : ((IDX_W+1)'(cur) + 1'b1);
    for (int i = 0; i < N_SLOTS; i++) begin
      pos = start + (IDX_W+1)'(i);
      if (!found && elig[pos[IDX_W-1:0]]) begin
        found   = 1'b1;
        nxt     = pos[IDX_W-1:0];
        wrapped = (pos >= (IDX_W+1)'(N_SLOTS));
      end
    end
  end

endmodule

// File: rtl/sat_sched.sv
// sat_sched: scenario scheduler between the register bank and the GPS
// generator core. Steps the core through a table of satellite configurations:
// load a slot, request code-phase alignment, dwell a number of C/A epochs,
// advance to the next eligible slot.
// Build option: SAT_SCHED_LOOP_EN - when defined the schedule wraps and runs
// continuously; otherwise one pass ends in DONE.
// Ports:
//   clk_in, rst_in_n          clock, asynchronous active-low reset
//   run_in                    level, schedule active
//   wr_*_in                   table write port (one-cycle wr_en_in strobe)
//   epoch_in                  C/A epoch start pulse from the core
//   code_phase_done_in        core reached the requested phase
//   enable_out, n_sat_out, doppler_out, snr_out, ca_phase_out   to the core
//   ca_phase_start_out        one-cycle phase-alignment request
//   slot_out                  active slot index
//   busy_out                  scheduler is stepping through slots
//   align_err_out             sticky align-timeout flag, cleared by run_in=0
module sat_sched
  import sat_sched_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int DWELL_W    = 8,
  parameter int ALIGN_TO_W = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic                       run_in,
  input  logic                       wr_en_in,
  input  logic [$clog2(N_SLOTS)-1:0] wr_addr_in,
  input  logic                       wr_valid_in,
  input  logic [N_SAT_W-1:0]         wr_n_sat_in,
  input  logic [DOPPLER_W-1:0]       wr_doppler_in,
  input  logic [SNR_W-1:0]           wr_snr_in,
  input  logic [CA_PHASE_W-1:0]      wr_ca_phase_in,
  input  logic [DWELL_W-1:0]         wr_dwell_in,
  input  logic                       epoch_in,
  input  logic                       code_phase_done_in,
  output logic                       enable_out,
  output logic [N_SAT_W-1:0]         n_sat_out,
  output logic [DOPPLER_W-1:0]       doppler_out,
  output logic [SNR_W-1:0]           snr_out,
  output logic [CA_PHASE_W-1:0]      ca_phase_out,
  output logic                       ca_phase_start_out,
  output logic [$clog2(N_SLOTS)-1:0] slot_out,
  output logic                       busy_out,
  output logic                       align_err_out
);

  localparam int IDX_W = $clog2(N_SLOTS);

`ifdef SAT_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  slot_t                 tbl [N_SLOTS];
  slot_t                 slot_w;
  logic [N_SLOTS-1:0]    elig;

  state_t                state;
  logic [IDX_W-1:0]      sel_idx;
  logic [ALIGN_TO_W-1:0] to_cnt;
  logic [ALIGN_TO_W-1:0] to_cnt_inc;
  logic [DWELL_W-1:0]    ep_cnt;
  logic [DWELL_W-1:0]    ep_cnt_inc;
  logic [DWELL_W-1:0]    cur_dwell;

  logic [IDX_W-1:0]      pk_nxt;
  logic                  pk_found;
  logic                  pk_wrapped;

  always_comb begin
    slot_w          = '0;
    slot_w.valid    = wr_valid_in;
    slot_w.n_sat    = wr_n_sat_in;
    slot_w.doppler  = wr_doppler_in;
    slot_w.snr      = wr_snr_in;
    slot_w.ca_phase = wr_ca_phase_in;
    slot_w.dwell    = DWELL_MAX_W'(wr_dwell_in);
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      elig[i] = tbl[i].valid && (tbl[i].dwell != '0);
    end
  end

  assign to_cnt_inc = to_cnt + 1'b1;
  assign ep_cnt_inc = ep_cnt + 1'b1;

  sat_sched_pick #(
    .N_SLOTS (N_SLOTS)
  ) u_pick (
    .elig      (elig),
    .cur       (slot_out),
    .from_idle (state == S_IDLE),
    .nxt       (pk_nxt),
    .found     (pk_found),
    .wrapped   (pk_wrapped)
  );

  // Slot table: writable in any state; the active slot's outputs only pick
  // up a rewrite at that slot's next LOAD because outputs are latched there.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en_in) begin
      tbl[wr_addr_in] <= slot_w;
    end
  end

  // Scheduler FSM with registered outputs. run_in=0 overrides every other
  // event in the same cycle.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state              <= S_IDLE;
      sel_idx            <= '0;
      to_cnt             <= '0;
      ep_cnt             <= '0;
      cur_dwell          <= '0;
      enable_out         <= 1'b0;
      busy_out           <= 1'b0;
      n_sat_out          <= '0;
      doppler_out        <= '0;
      snr_out            <= '0;
      ca_phase_out       <= '0;
      ca_phase_start_out <= 1'b0;
      slot_out           <= '0;
      align_err_out      <= 1'b0;
    end else begin
      ca_phase_start_out <= 1'b0;
      if (!run_in) begin
        state         <= S_IDLE;
        enable_out    <= 1'b0;
        busy_out      <= 1'b0;
        align_err_out <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pk_found) begin
              sel_idx    <= pk_nxt;
              state      <= S_LOAD;
              enable_out <= 1'b1;
              busy_out   <= 1'b1;
            end
          end
          S_LOAD: begin
            slot_out           <= sel_idx;
            n_sat_out          <= tbl[sel_idx].n_sat;
            doppler_out        <= tbl[sel_idx].doppler;
            snr_out            <= tbl[sel_idx].snr;
            ca_phase_out       <= tbl[sel_idx].ca_phase;
            cur_dwell          <= tbl[sel_idx].dwell[DWELL_W-1:0];
            to_cnt             <= '0;
            ep_cnt             <= '0;
            ca_phase_start_out <= 1'b1;
            state              <= S_ALIGN;
          end
          S_ALIGN: begin
            // to_cnt==0 marks the first ALIGN cycle, where the core has not
            // yet seen the start request, so done is ignored there.
            if ((to_cnt != '0) && code_phase_done_in) begin
              state <= S_DWELL;
            end else if (to_cnt_inc == '1) begin
              align_err_out <= 1'b1;
              state         <= S_NEXT;
            end else begin
              to_cnt <= to_cnt_inc;
            end
          end
          S_DWELL: begin
            if (epoch_in) begin
              if (ep_cnt_inc == cur_dwell) begin
                state <= S_NEXT;
              end else begin
                ep_cnt <= ep_cnt_inc;
              end
            end
          end
          S_NEXT: begin
            if (!pk_found) begin
              state      <= S_IDLE;
              enable_out <= 1'b0;
              busy_out   <= 1'b0;
            end else if (!pk_wrapped || LOOP_EN) begin
              sel_idx <= pk_nxt;
              state   <= S_LOAD;
            end else begin
              state      <= S_DONE;
              enable_out <= 1'b0;
              busy_out   <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state      <= S_IDLE;
            enable_out <= 1'b0;
            busy_out   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sat_sched.sv
// tb_sat_sched: self-checking bench for sat_sched. A behavioural model of the
// schedule runs alongside the DUT and every output is compared on each
// falling clock edge; directed scenarios add hand-computed literal checks.
// Honours SAT_SCHED_LOOP_EN the same way as the design.
module tb_sat_sched;

  localparam int N    = 4;
  localparam int TO_W = 4;
  localparam int TO_N = (1 << TO_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_n_sat = '0;
  logic [7:0]  wr_dop = '0;
  logic [7:0]  wr_snr = '0;
  logic [15:0] wr_ph = '0;
  logic [7:0]  wr_dwell = '0;
  logic        epoch = 1'b0;
  logic        cpd = 1'b0;

  logic        en, cps, busy, err;
  logic [4:0]  n_sat;
  logic [7:0]  dop, snr;
  logic [15:0] ph;
  logic [1:0]  slot;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sat_sched #(
    .N_SLOTS    (N),
    .DWELL_W    (8),
    .ALIGN_TO_W (TO_W)
  ) dut (
    .clk_in             (clk),
    .rst_in_n           (rst_n),
    .run_in             (run),
    .wr_en_in           (wr_en),
    .wr_addr_in         (wr_addr),
    .wr_valid_in        (wr_valid),
    .wr_n_sat_in        (wr_n_sat),
    .wr_doppler_in      (wr_dop),
    .wr_snr_in          (wr_snr),
    .wr_ca_phase_in     (wr_ph),
    .wr_dwell_in        (wr_dwell),
    .epoch_in           (epoch),
    .code_phase_done_in (cpd),
    .enable_out         (en),
    .n_sat_out          (n_sat),
    .doppler_out        (dop),
    .snr_out            (snr),
    .ca_phase_out       (ph),
    .ca_phase_start_out (cps),
    .slot_out           (slot),
    .busy_out           (busy),
    .align_err_out      (err)
  );

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_ALIGN = 2, M_DWELL = 3, M_NEXT = 4, M_DONE = 5;
`ifdef SAT_SCHED_LOOP_EN
  localparam bit M_LOOP = 1'b1;
`else
  localparam bit M_LOOP = 1'b0;
`endif

  int t_valid [N];
  int t_nsat  [N];
  int t_dop   [N];
  int t_snr   [N];
  int t_ph    [N];
  int t_dwell [N];

  int m_mode = M_IDLE;
  int m_pend = 0;
  int m_age  = 0;
  int m_left = 0;
  int m_en = 0, m_busy = 0, m_cps = 0, m_err = 0;
  int m_nsat = 0, m_dop = 0, m_snr = 0, m_ph = 0, m_slot = 0;

  function automatic bit m_elig(int i);
    return (t_valid[i] != 0) && (t_dwell[i] != 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_pend = 0; m_age = 0; m_left = 0;
      m_en = 0; m_busy = 0; m_cps = 0; m_err = 0;
      m_nsat = 0; m_dop = 0; m_snr = 0; m_ph = 0; m_slot = 0;
      for (int i = 0; i < N; i++) begin
        t_valid[i] = 0; t_nsat[i] = 0; t_dop[i] = 0;
        t_snr[i] = 0; t_ph[i] = 0; t_dwell[i] = 0;
      end
    end else begin
      m_cps = 0;
      if (!run) begin
        m_mode = M_IDLE; m_en = 0; m_busy = 0; m_err = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin
            for (int k = N - 1; k >= 0; k--) begin
              if (m_elig(k)) begin
                m_pend = k; m_mode = M_LOAD;
              end
            end
            if (m_mode == M_LOAD) begin m_en = 1; m_busy = 1; end
          end
          M_LOAD: begin
            m_slot = m_pend;
            m_nsat = t_nsat[m_pend]; m_dop = t_dop[m_pend];
            m_snr = t_snr[m_pend]; m_ph = t_ph[m_pend];
            m_left = t_dwell[m_pend];
            m_age = 0; m_cps = 1; m_mode = M_ALIGN;
          end
          M_ALIGN: begin
            m_age++;
            if (m_age >= 2 && cpd) m_mode = M_DWELL;
            else if (m_age == TO_N) begin m_err = 1; m_mode = M_NEXT; end
          end
          M_DWELL: begin
            if (epoch) begin
              m_left--;
              if (m_left == 0) m_mode = M_NEXT;
            end
          end
          M_NEXT: begin
            int  hit;
            bit  wrap;
            hit = -1; wrap = 0;
            for (int k = 1; k <= N; k++) begin
              if (hit < 0 && m_elig((m_slot + k) % N)) begin
                hit = (m_slot + k) % N;
                wrap = (m_slot + k) >= N;
              end
            end
            if (hit < 0) begin
              m_mode = M_IDLE; m_en = 0; m_busy = 0;
            end else if (!wrap || M_LOOP) begin
              m_pend = hit; m_mode = M_LOAD;
            end else begin
              m_mode = M_DONE; m_en = 0; m_busy = 0;
            end
          end
          default: ;
        endcase
      end
      if (wr_en) begin
        t_valid[wr_addr] = wr_valid; t_nsat[wr_addr] = wr_n_sat;
        t_dop[wr_addr] = wr_dop; t_snr[wr_addr] = wr_snr;
        t_ph[wr_addr] = wr_ph; t_dwell[wr_addr] = wr_dwell;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  logic [46:0] dut_vec, exp_vec;
  assign dut_vec = {en, busy, cps, err, slot, n_sat, dop, snr, ph};
  always_comb begin
    exp_vec = {m_en[0], m_busy[0], m_cps[0], m_err[0], m_slot[1:0],
               m_nsat[4:0], m_dop[7:0], m_snr[7:0], m_ph[15:0]};
  end

  always @(negedge clk) begin
    n_chk++;
    if (dut_vec !== exp_vec) begin
      n_err++;
      $display("FAIL model t=%0t got=%h want=%h", $time, dut_vec, exp_vec);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic v, input logic [4:0] ns,
                    input logic [7:0] d, input logic [7:0] s,
                    input logic [15:0] p, input logic [7:0] dw);
    wr_addr = a; wr_valid = v; wr_n_sat = ns; wr_dop = d;
    wr_snr = s; wr_ph = p; wr_dwell = dw; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_epoch();
    epoch = 1'b1;
    tick();
    epoch = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("reset_outputs", 32'(dut_vec), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic schedule: slot0, slot1 empty, slot2.
    wr(2'd0, 1'b1, 5'd3, 8'h10, 8'h20, 16'h0100, 8'd2);
    wr(2'd2, 1'b1, 5'd7, 8'h33, 8'h44, 16'h0200, 8'd1);
    run = 1'b1;
    tick();
    chk("load_enable", 32'(en), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    tick();
    chk("align0_start", 32'(cps), 32'd1);
    chk("align0_slot", 32'(slot), 32'd0);
    chk("align0_cfg", {n_sat, dop, snr}, {11'h0, 5'd3, 8'h10, 8'h20});
    chk("align0_phase", 32'(ph), 32'h0100);
    tick();
    chk("align0_start_once", 32'(cps), 32'd0);
    cpd = 1'b1; epoch = 1'b1;       // epoch during ALIGN must not count
    tick();
    cpd = 1'b0; epoch = 1'b0;
    pulse_epoch();
    chk("dwell0_hold", {30'h0, slot}, 32'd0);
    chk("dwell0_en", 32'(en), 32'd1);
    pulse_epoch();
    tick();
    tick();
    chk("align2_slot", 32'(slot), 32'd2);
    chk("align2_prn", 32'(n_sat), 32'd7);
    chk("align2_start", 32'(cps), 32'd1);
    tick();
    cpd = 1'b1;
    tick();
    cpd = 1'b0;
    pulse_epoch();
    tick();
`ifdef SAT_SCHED_LOOP_EN
    chk("loop_load_en", 32'(en), 32'd1);
    tick();
    chk("loop_start", 32'(cps), 32'd1);
    chk("loop_slot", 32'(slot), 32'd0);
`else
    chk("done_en", 32'(en), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    tick();
    chk("done_hold", 32'({en, busy}), 32'd0);
`endif
    run = 1'b0;
    tick();
    chk("stop_outputs", 32'({en, busy, cps}), 32'd0);

    // Align timeout on slot0, advance to slot2, clear by run_in=0.
    run = 1'b1;
    tick(); tick();
    repeat (TO_N - 1) tick();
    chk("timeout_pre_err", 32'(err), 32'd0);
    chk("timeout_pre_en", 32'(en), 32'd1);
    tick();
    chk("timeout_err", 32'(err), 32'd1);
    tick(); tick();
    chk("timeout_adv_slot", 32'(slot), 32'd2);
    chk("timeout_err_sticky", 32'(err), 32'd1);
    run = 1'b0;
    tick();
    chk("timeout_err_clear", 32'(err), 32'd0);

    // Drop run_in in DWELL together with an epoch pulse.
    run = 1'b1;
    tick(); tick(); tick();
    cpd = 1'b1;
    tick();
    cpd = 1'b0;
    pulse_epoch();
    chk("drop_pre_busy", 32'(busy), 32'd1);
    run = 1'b0; epoch = 1'b1;
    tick();
    epoch = 1'b0;
    chk("drop_outputs", 32'({en, busy, cps}), 32'd0);
    chk("drop_hold_cfg", 32'({slot, n_sat}), 32'({2'd0, 5'd3}));

    // Rewrite the active slot's Doppler mid-DWELL.
    run = 1'b1;
    tick(); tick(); tick();
    cpd = 1'b1;
    tick();
    cpd = 1'b0;
    wr(2'd0, 1'b1, 5'd3, 8'h55, 8'h20, 16'h0100, 8'd2);
    tick();
    chk("rewrite_hold", 32'(dop), 32'h10);
    pulse_epoch();
    chk("rewrite_hold2", 32'(dop), 32'h10);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick(); tick();
    chk("rewrite_reload", 32'(dop), 32'h55);
    chk("rewrite_start", 32'(cps), 32'd1);

    // Asynchronous reset mid-ALIGN, then run with an empty table.
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(dut_vec), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_en", 32'(en), 32'd0);
    run = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
